traffic_phase_fsm: RTL and testbench

- Phase sequencer for the traffic light controller; sits directly upstream of the Timer stage.
- Drives the Timer's interval value and start strobe, and consumes its one-cycle expired pulse.
- Drives main/side-street lamps and the pedestrian walk lamp from the current phase.
- Uses a registered side-street sensor and a pedestrian walk-request pulse, both already synchronised, to choose between base, extended and walk phases.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/walk_request_latch.sv | 26 ++
 rtl/traffic_phase_fsm.sv | 118 +++++++++++
 tb/tb_traffic_phase_fsm.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light phase sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        MG_BASE = 3'd0,
        MG_EXT  = 3'd1,
        MY      = 3'd2,
        WALK    = 3'd3,
        SG_BASE = 3'd4,
        SG_EXT  = 3'd5,
        SY      = 3'd6
    } phase_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int DEF_T_BASE = 6;
    localparam int DEF_T_EXT  = 3;
    localparam int DEF_T_YEL  = 2;
    localparam int DEF_T_WALK = 3;

    // Cycles the Timer needs to reload before its expired pulse can be trusted.
    localparam logic [1:0] GUARD_LOAD = 2'd2;

endpackage

// File: rtl/walk_request_latch.sv
// Holds a pedestrian walk request until the WALK phase is entered; clear wins over set.
module walk_request_latch (
    input  logic clk,
    input  logic rst,
    input  logic wr_req,
    input  logic walk_enter,
    input  logic in_walk,
    output logic walk_pending,
    output logic wr_ack
);

    always_ff @(posedge clk) begin
        if (rst) begin
            walk_pending <= 1'b0;
            wr_ack       <= 1'b0;
        end else begin
            wr_ack <= walk_enter;
            // Requests arriving while the walk is being served are already satisfied.
            if (walk_enter)
                walk_pending <= 1'b0;
            else if (wr_req && !in_walk)
                walk_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Traffic phase sequencer: chooses the next phase on a guarded Timer expiry and
// drives registered lamps, interval value and the Timer restart strobe.
module traffic_phase_fsm
    import traffic_pkg::*;
#(
    parameter int T_BASE = DEF_T_BASE,
    parameter int T_EXT  = DEF_T_EXT,
    parameter int T_YEL  = DEF_T_YEL,
    parameter int T_WALK = DEF_T_WALK
) (
    input  logic       clk,
    input  logic       Reset_Sync,
    input  logic       Sensor_Sync,
    input  logic       WR_Sync,
    input  logic       expired,
    output logic [3:0] Value,
    output logic       start_timer,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       walk_lamp,
    output logic       WR_Reset
);

    if (T_BASE < 1 || T_BASE > 15 || T_EXT < 1 || T_EXT > 15 ||
        T_YEL < 1 || T_YEL > 15 || T_WALK < 1 || T_WALK > 15) begin : g_bad_interval
        $error("traffic_phase_fsm: interval parameters must lie in 1..15");
    end

    phase_e     state, nxt;
    logic       boot;
    logic [1:0] guard;
    logic       enter;
    logic       walk_pending;
    logic [3:0] nxt_value;
    logic [2:0] nxt_main, nxt_side;
    logic       nxt_walk;

    walk_request_latch u_walk_latch (
        .clk          (clk),
        .rst          (Reset_Sync),
        .wr_req       (WR_Sync),
        .walk_enter   (enter && (nxt == WALK)),
        .in_walk      (state == WALK),
        .walk_pending (walk_pending),
        .wr_ack       (WR_Reset)
    );

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state <= MG_BASE;
            boot  <= 1'b1;
        end else begin
            state <= nxt;
            boot  <= 1'b0;
        end
    end

    // boot marks the all-red cycle after reset; leaving it is an MG_BASE entry.
    always_comb begin
        nxt   = state;
        enter = 1'b0;
        if (boot) begin
            nxt   = MG_BASE;
            enter = 1'b1;
        end else if (expired && guard == 2'd0) begin
            enter = 1'b1;
            case (state)
                MG_BASE: nxt = Sensor_Sync ? MY : MG_EXT;
                MG_EXT:  nxt = MY;
                MY:      nxt = walk_pending ? WALK : SG_BASE;
                WALK:    nxt = SG_BASE;
                SG_BASE: nxt = Sensor_Sync ? SG_EXT : SY;
                SG_EXT:  nxt = SY;
                SY:      nxt = MG_BASE;
                default: nxt = MG_BASE;
            endcase
        end
    end

    always_comb begin
        nxt_value = 4'(T_BASE);
        nxt_main  = LAMP_RED;
        nxt_side  = LAMP_RED;
        nxt_walk  = 1'b0;
        case (nxt)
            MG_BASE: nxt_main = LAMP_GRN;
            MG_EXT:  begin nxt_value = 4'(T_EXT);  nxt_main = LAMP_GRN; end
            MY:      begin nxt_value = 4'(T_YEL);  nxt_main = LAMP_YEL; end
            WALK:    begin nxt_value = 4'(T_WALK); nxt_walk = 1'b1;     end
            SG_BASE: nxt_side = LAMP_GRN;
            SG_EXT:  begin nxt_value = 4'(T_EXT);  nxt_side = LAMP_GRN; end
            SY:      begin nxt_value = 4'(T_YEL);  nxt_side = LAMP_YEL; end
            default: nxt_value = 4'(T_BASE);
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            guard       <= GUARD_LOAD;
            start_timer <= 1'b0;
            Value       <= 4'(T_BASE);
            main_lamp   <= LAMP_RED;
            side_lamp   <= LAMP_RED;
            walk_lamp   <= 1'b0;
        end else begin
            start_timer <= enter;
            Value       <= nxt_value;
            main_lamp   <= nxt_main;
            side_lamp   <= nxt_side;
            walk_lamp   <= nxt_walk;
            if (enter)
                guard <= GUARD_LOAD;
            else if (guard != 2'd0)
                guard <= guard - 2'd1;
        end
    end

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Bench for traffic_phase_fsm: phase-table model checked every cycle, plus literal spot checks.
module tb_traffic_phase_fsm;

    logic       clk = 1'b0;
    logic       Reset_Sync = 1'b1;
    logic       Sensor_Sync = 1'b0;
    logic       WR_Sync = 1'b0;
    logic       expired = 1'b0;
    logic [3:0] Value;
    logic       start_timer;
    logic [2:0] main_lamp, side_lamp;
    logic       walk_lamp;
    logic       WR_Reset;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    // Phase index: 0 MG_BASE, 1 MG_EXT, 2 MY, 3 WALK, 4 SG_BASE, 5 SG_EXT, 6 SY
    int         tbl_val  [7] = '{6, 3, 2, 3, 6, 3, 2};
    logic [2:0] tbl_main [7] = '{G, G, Y, R, R, R, R};
    logic [2:0] tbl_side [7] = '{R, R, R, R, G, G, Y};

    bit m_allred = 1'b1;
    int m_phase  = 0;
    int m_age    = 0;
    bit m_pend   = 1'b0;

    traffic_phase_fsm dut (
        .clk         (clk),
        .Reset_Sync  (Reset_Sync),
        .Sensor_Sync (Sensor_Sync),
        .WR_Sync     (WR_Sync),
        .expired     (expired),
        .Value       (Value),
        .start_timer (start_timer),
        .main_lamp   (main_lamp),
        .side_lamp   (side_lamp),
        .walk_lamp   (walk_lamp),
        .WR_Reset    (WR_Reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic int succ(input int p, input bit sens, input bit pend);
        case (p)
            0: return sens ? 2 : 1;
            1: return 2;
            2: return pend ? 3 : 4;
            3: return 4;
            4: return sens ? 5 : 6;
            5: return 6;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_step(input bit rst, input bit exp_i, input bit sens, input bit wr);
        int np;
        bit entered;
        if (rst) begin
            m_allred = 1'b1;
            m_phase  = 0;
            m_pend   = 1'b0;
            m_age    = 0;
        end else begin
            np = m_phase;
            entered = 1'b0;
            if (m_allred) begin
                np = 0;
                entered = 1'b1;
            end else if (exp_i && m_age >= 2) begin
                np = succ(m_phase, sens, m_pend);
                entered = 1'b1;
            end
            if (entered && np == 3)
                m_pend = 1'b0;
            else if (wr && m_phase != 3)
                m_pend = 1'b1;
            m_age    = entered ? 0 : m_age + 1;
            m_phase  = np;
            m_allred = 1'b0;
        end
    endtask

    task automatic cyc(input bit exp_i, input bit sens, input bit wr, input bit rst);
        expired     = exp_i;
        Sensor_Sync = sens;
        WR_Sync     = wr;
        Reset_Sync  = rst;
        @(posedge clk);
        model_step(rst, exp_i, sens, wr);
        chk_en = 1'b1;
        #1;
    endtask

    task automatic dwell(input int idle, input bit sens);
        repeat (idle) cyc(1'b0, sens, 1'b0, 1'b0);
        cyc(1'b1, sens, 1'b0, 1'b0);
    endtask

    task automatic lit(input string nm, input int v, input logic [2:0] mn, input logic [2:0] sd,
                       input bit wk, input bit st);
        chk({nm, ".Value"}, int'(Value), v);
        chk({nm, ".main"}, int'(main_lamp), int'(mn));
        chk({nm, ".side"}, int'(side_lamp), int'(sd));
        chk({nm, ".walk"}, int'(walk_lamp), int'(wk));
        chk({nm, ".start"}, int'(start_timer), int'(st));
    endtask

    // Every-cycle comparison against the model plus the safety invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (m_allred) begin
                    chk("m.Value", int'(Value), 6);
                    chk("m.main", int'(main_lamp), int'(R));
                    chk("m.side", int'(side_lamp), int'(R));
                    chk("m.walk", int'(walk_lamp), 0);
                    chk("m.start", int'(start_timer), 0);
                    chk("m.WR_Reset", int'(WR_Reset), 0);
                end else begin
                    chk("m.Value", int'(Value), tbl_val[m_phase]);
                    chk("m.main", int'(main_lamp), int'(tbl_main[m_phase]));
                    chk("m.side", int'(side_lamp), int'(tbl_side[m_phase]));
                    chk("m.walk", int'(walk_lamp), int'(m_phase == 3));
                    chk("m.start", int'(start_timer), int'(m_age == 0));
                    chk("m.WR_Reset", int'(WR_Reset), int'(m_age == 0 && m_phase == 3));
                end
                chk("inv.one_street_open", int'(main_lamp != R && side_lamp != R), 0);
                chk("inv.walk_all_red", int'(walk_lamp && (main_lamp != R || side_lamp != R)), 0);
                chk("inv.main_onehot", int'($countones(main_lamp)), 1);
                chk("inv.side_onehot", int'($countones(side_lamp)), 1);
            end
        end
    end

    initial begin
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        lit("reset", 6, R, R, 0, 0);
        chk("reset.WR_Reset", int'(WR_Reset), 0);

        // Plain cycle, no sensor, no walk
        cyc(0, 0, 0, 0);
        lit("boot_mg_base", 6, G, R, 0, 1);
        dwell(5, 0); lit("mg_ext", 3, G, R, 0, 1);
        dwell(5, 0); lit("my", 2, Y, R, 0, 1);
        dwell(5, 0); lit("sg_base", 6, R, G, 0, 1);
        dwell(5, 0); lit("sy", 2, R, Y, 0, 1);
        dwell(5, 0); lit("mg_base", 6, G, R, 0, 1);

        // Sensor held: skip MG_EXT, take SG_EXT
        dwell(5, 1); lit("sens_my", 2, Y, R, 0, 1);
        dwell(5, 1); lit("sens_sg_base", 6, R, G, 0, 1);
        dwell(5, 1); lit("sens_sg_ext", 3, R, G, 0, 1);
        dwell(5, 1); lit("sens_sy", 2, R, Y, 0, 1);
        dwell(5, 0); lit("sens_mg_base", 6, G, R, 0, 1);

        // Walk request during MG_EXT
        dwell(5, 0); lit("w_mg_ext", 3, G, R, 0, 1);
        cyc(0, 0, 1, 0);
        dwell(4, 0); lit("w_my", 2, Y, R, 0, 1);
        dwell(5, 0); lit("w_walk", 3, R, R, 1, 1);
        chk("w_walk.WR_Reset", int'(WR_Reset), 1);
        cyc(0, 0, 1, 0);
        chk("w_walk_next.WR_Reset", int'(WR_Reset), 0);
        dwell(4, 0); lit("w_sg_base", 6, R, G, 0, 1);
        dwell(5, 0); dwell(5, 0); dwell(5, 0);
        dwell(5, 0); lit("w_no_repeat_my", 2, Y, R, 0, 1);
        dwell(5, 0); lit("w_no_repeat_sg", 6, R, G, 0, 1);

        // Guard: expiry in strobe cycle and the next is ignored
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        lit("guard_hold", 6, R, G, 0, 0);
        cyc(1, 0, 0, 0);
        lit("guard_accept", 2, R, Y, 0, 1);

        // Reset in SG_EXT
        dwell(5, 1); dwell(5, 1); dwell(5, 1);
        dwell(5, 1); lit("r_sg_ext", 3, R, G, 0, 1);
        cyc(0, 1, 0, 1);
        lit("r_all_red", 6, R, R, 0, 0);
        cyc(0, 0, 0, 0);
        lit("r_restart", 6, G, R, 0, 1);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 499) == 0));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
